tmr_gp: RTL and testbench

Parametrised general-purpose timer; successor to the fixed 32-bit single-match timer 0. Adds configurable counter width, NUM_CH match channels, a prescaler, a one-shot mode and two external synchronised tick sources. Sits behind the peripheral SFR file, which owns the registers and flags. The block receives decoded control/value fields and returns the count, flag-set pulses and output pins.

---
 rtl/tmr_gp_pkg.sv | 18 +
 rtl/tmr_gp_sync_edge.sv | 13 +
 rtl/tmr_gp.sv | 99 +++++++++
 tb/tb_tmr_gp.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/tmr_gp_pkg.sv
// tmr_gp_pkg: control word layout, tick-source and FSM state encodings for tmr_gp.
package tmr_gp_pkg;
  typedef enum logic [1:0] {CLK_SYS, CLK_EXT0, CLK_EXT1, CLK_NONE} tmr_clksrc_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} tmr_state_e;
  // psc occupies [31:16]; the timer uses only its low PSC_W bits
  typedef struct packed {
    logic [15:0] psc;
    logic [5:0]  rsv_hi;
    tmr_clksrc_e clksrc;
    logic        oen;
    logic        oinv;
    logic [1:0]  rsv_lo;
    logic        os;
    logic        ld;
    logic        rst;
    logic        on;
  } tmr_gp_ctrl_t;
endpackage

// File: rtl/tmr_gp_sync_edge.sv
// tmr_sync_edge: 2-FF synchroniser plus edge-detect flop; o_rise marks a synchronised rising edge.
module tmr_sync_edge (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_rise
);
  logic [2:0] r_sh;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_sh <= '0;
    else r_sh <= {r_sh[1:0], i_async};
  assign o_rise = r_sh[1] & ~r_sh[2];
endmodule

// File: rtl/tmr_gp.sv
// tmr_gp: parametrised timer with prescaler, one-shot mode, external ticks and match outputs.
// Build option TMR_GP_AUTO_RELOAD_EN: wrap reloads tmr_ld_val_i instead of 0.
module tmr_gp
  import tmr_gp_pkg::*;
#(
  parameter int TMR_W  = 32,
  parameter int NUM_CH = 2,
  parameter int PSC_W  = 8
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst_n,
  input  logic [31:0]             tmr_ctrl_i,
  input  logic [TMR_W-1:0]        tmr_ld_val_i,
  input  logic [NUM_CH*TMR_W-1:0] tmr_mch_i,
  input  logic [1:0]              ext_clk_i,
  output logic [TMR_W-1:0]        tmr_val_o,
  output logic [NUM_CH-1:0]       match_f_set_o,
  output logic                    ovf_f_set_o,
  output logic [NUM_CH-1:0]       tmr_out_o,
  output logic                    tmr_busy_o
);
  tmr_gp_ctrl_t      w_ctrl;
  tmr_state_e        r_state, w_state_nx;
  logic [TMR_W-1:0]  r_cnt, w_cnt_inc, w_cnt_nx;
  logic [PSC_W-1:0]  r_psc, w_psc_nx;
  logic [NUM_CH-1:0] r_tog, r_mch, w_mch;
  logic [1:0]        w_ext_rise;
  logic              r_rst_d, r_ld_d, r_ovf;
  logic              w_rst_stb, w_ld_stb, w_tick, w_cnt_tick, w_en, w_wrap, w_unused_ctrl;

  assign w_ctrl        = tmr_gp_ctrl_t'(tmr_ctrl_i);
  assign w_unused_ctrl = ^w_ctrl;
  assign w_rst_stb     = w_ctrl.rst & ~r_rst_d;
  assign w_ld_stb      = w_ctrl.ld & ~r_ld_d & ~w_rst_stb;
  assign w_tick        = (w_ctrl.clksrc == CLK_SYS)  ? 1'b1 :
                         (w_ctrl.clksrc == CLK_EXT0) ? w_ext_rise[0] :
                         (w_ctrl.clksrc == CLK_EXT1) ? w_ext_rise[1] : 1'b0;
  // a strobe in the same cycle swallows the tick
  assign w_cnt_tick    = (r_state == RUN) & w_ctrl.on & w_tick & ~w_rst_stb & ~w_ld_stb;
  assign w_en          = w_cnt_tick & (r_psc == w_ctrl.psc[PSC_W-1:0]);
  assign w_wrap        = w_en & (&r_cnt);
`ifdef TMR_GP_AUTO_RELOAD_EN
  assign w_cnt_inc     = w_wrap ? tmr_ld_val_i : r_cnt + 1'b1;
`else
  assign w_cnt_inc     = r_cnt + 1'b1;
`endif
  assign w_cnt_nx      = w_rst_stb ? '0 : w_ld_stb ? tmr_ld_val_i : w_en ? w_cnt_inc : r_cnt;
  assign w_psc_nx      = (w_rst_stb | w_ld_stb | w_en) ? '0 : w_cnt_tick ? r_psc + 1'b1 : r_psc;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_mch[i] = w_en & (w_cnt_inc == tmr_mch_i[i*TMR_W +: TMR_W]);
  end

  for (genvar e = 0; e < 2; e++) begin : g_sync
    tmr_sync_edge u_sync (
      .i_clk   (sys_clk),
      .i_rst_n (sys_rst_n),
      .i_async (ext_clk_i[e]),
      .o_rise  (w_ext_rise[e])
    );
  end

  always_comb begin
    w_state_nx = r_state;
    if (!w_ctrl.on) w_state_nx = IDLE;
    else if (r_state == IDLE) w_state_nx = RUN;
    else if (r_state == RUN && w_wrap && w_ctrl.os) w_state_nx = DONE;
    else if (r_state == DONE && w_rst_stb) w_state_nx = RUN;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) r_state <= IDLE;
    else r_state <= w_state_nx;

  always_ff @(posedge sys_clk or negedge sys_rst_n)
    if (!sys_rst_n) begin
      r_cnt   <= '0;
      r_psc   <= '0;
      r_tog   <= '0;
      r_mch   <= '0;
      r_ovf   <= 1'b0;
      r_rst_d <= 1'b0;
      r_ld_d  <= 1'b0;
    end else begin
      r_cnt   <= w_cnt_nx;
      r_psc   <= w_psc_nx;
      r_tog   <= w_rst_stb ? '0 : r_tog ^ w_mch;
      r_mch   <= w_mch;
      r_ovf   <= w_wrap;
      r_rst_d <= w_ctrl.rst;
      r_ld_d  <= w_ctrl.ld;
    end

  assign tmr_val_o     = r_cnt;
  assign match_f_set_o = r_mch;
  assign ovf_f_set_o   = r_ovf;
  assign tmr_out_o     = w_ctrl.oen ? (r_tog ^ {NUM_CH{w_ctrl.oinv}}) : '0;
  assign tmr_busy_o    = (r_state == RUN);
endmodule

// File: tb/tb_tmr_gp.sv
// tb_tmr_gp: directed and random checks of tmr_gp (TMR_W=8) against a cycle-level behavioural model.
module tb_tmr_gp;
  localparam int W = 8, NCH = 2, PW = 8;
  localparam int MAXV = (1 << W) - 1;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [31:0] ctrl;
  logic [W-1:0] ld_val = '0;
  logic [NCH*W-1:0] mch = '0;
  logic [1:0] ext = '0;
  logic [W-1:0] val;
  logic [NCH-1:0] mf, tout;
  logic ovf, busy;
  logic c_on = 0, c_rst = 0, c_ld = 0, c_os = 0, c_oinv = 0, c_oen = 0;
  logic [1:0] c_src = 0, c_lo = 0;
  logic [7:0] c_psc = 0, c_hi = 0;
  logic [5:0] c_mid = 0;
  int n_chk = 0, n_err = 0, n_ovf = 0, n_m0 = 0;
  int m_cnt = 0, m_psc = 0, m_mode = 0;
  bit [NCH-1:0] m_tog = '0, m_mf = '0;
  bit m_ovf = 0, m_rp = 0, m_lp = 0;
  bit [2:0] m_eh [2];

  assign ctrl = {c_hi, c_psc, c_mid, c_src, c_oen, c_oinv, c_lo, c_os, c_ld, c_rst, c_on};
  always #5 clk = ~clk;

  tmr_gp #(.TMR_W(W), .NUM_CH(NCH), .PSC_W(PW)) dut (
    .sys_clk(clk), .sys_rst_n(rst_n), .tmr_ctrl_i(ctrl), .tmr_ld_val_i(ld_val),
    .tmr_mch_i(mch), .ext_clk_i(ext), .tmr_val_o(val), .match_f_set_o(mf),
    .ovf_f_set_o(ovf), .tmr_out_o(tout), .tmr_busy_o(busy));

  // mode: 0 stopped, 1 counting, 2 one-shot finished
  function automatic void model_reset();
    m_cnt = 0; m_psc = 0; m_mode = 0; m_tog = '0; m_mf = '0; m_ovf = 0; m_rp = 0; m_lp = 0;
    m_eh[0] = '0; m_eh[1] = '0;
  endfunction

  function automatic void model_step();
    bit rs, ls, tk, wrapped;
    int nxt;
    rs = c_rst && !m_rp;
    ls = c_ld && !m_lp && !rs;
    m_rp = c_rst; m_lp = c_ld;
    tk = (c_src == 0) ? 1'b1 : (c_src == 1) ? (m_eh[0][1] && !m_eh[0][2]) :
         (c_src == 2) ? (m_eh[1][1] && !m_eh[1][2]) : 1'b0;
    for (int s = 0; s < 2; s++) m_eh[s] = {m_eh[s][1:0], ext[s]};
    m_mf = '0; m_ovf = 0; wrapped = 0;
    if (rs) begin m_cnt = 0; m_psc = 0; m_tog = '0; end
    else if (ls) begin m_cnt = int'(ld_val); m_psc = 0; end
    else if (m_mode == 1 && c_on && tk) begin
      if (m_psc != int'(c_psc)) m_psc = (m_psc + 1) % 256;
      else begin
        m_psc = 0;
        wrapped = (m_cnt == MAXV);
`ifdef TMR_GP_AUTO_RELOAD_EN
        nxt = wrapped ? int'(ld_val) : m_cnt + 1;
`else
        nxt = (m_cnt + 1) % (MAXV + 1);
`endif
        m_ovf = wrapped;
        for (int ch = 0; ch < NCH; ch++)
          if (nxt == int'(mch[ch*W +: W])) begin m_mf[ch] = 1; m_tog[ch] = ~m_tog[ch]; end
        m_cnt = nxt;
      end
    end
    if (!c_on) m_mode = 0;
    else if (m_mode == 0) m_mode = 1;
    else if (m_mode == 1 && wrapped && c_os) m_mode = 2;
    else if (m_mode == 2 && rs) m_mode = 1;
  endfunction

  function automatic logic [31:0] exp_vec();
    logic [NCH-1:0] o;
    o = c_oen ? (m_tog ^ {NCH{c_oinv}}) : '0;
    return 32'({W'(m_cnt), m_mf, m_ovf, o, m_mode == 1});
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(int n, string tag);
    repeat (n) begin
      @(posedge clk);
      model_step();
      #1;
      chk(tag, 32'({val, mf, ovf, tout, busy}), exp_vec());
      n_ovf += int'(ovf);
      n_m0 += int'(mf[0]);
      @(negedge clk);
    end
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #1 chk("reset_outputs", 32'({val, mf, ovf, tout, busy}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    // free-running wrap
    c_on = 1; cyc(1, "t1_start");
    n_ovf = 0; cyc(256, "t1_run");
    chk("t1_val", 32'(val), 32'h0);
    chk("t1_ovf_count", 32'(n_ovf), 32'd1);
    chk("t1_ovf_last", 32'(ovf), 32'd1);
    // prescaled match and output pin
    c_on = 0; cyc(1, "t2_stop");
    c_rst = 1; cyc(1, "t2_rst"); c_rst = 0;
    c_psc = 3; mch = {8'd200, 8'd5}; c_oen = 1; c_on = 1;
    cyc(1, "t2_start");
    n_m0 = 0; cyc(19, "t2_run");
    chk("t2_val19", 32'(val), 32'd4);
    chk("t2_nomatch", 32'(n_m0), 32'd0);
    chk("t2_out_before", 32'(tout[0]), 32'd0);
    cyc(1, "t2_match");
    chk("t2_val20", 32'(val), 32'd5);
    chk("t2_match_pulse", 32'(mf[0]), 32'd1);
    chk("t2_out_after", 32'(tout[0]), 32'd1);
    c_oinv = 1; #1;
    chk("t2_out_inv", 32'(tout[0]), 32'd0);
    // one-shot
    c_on = 0; c_oen = 0; c_oinv = 0; c_psc = 0; c_os = 1; ld_val = 8'hFE;
    cyc(1, "t3_stop");
    c_ld = 1; cyc(1, "t3_ld"); c_ld = 0;
    chk("t3_loaded", 32'(val), 32'hFE);
    c_on = 1; cyc(1, "t3_start");
    cyc(1, "t3_ff");
    chk("t3_val_ff", 32'(val), 32'hFF);
    n_ovf = 0; cyc(1, "t3_wrap");
    chk("t3_val_wrap", 32'(val), 32'h0);
    chk("t3_ovf", 32'(ovf), 32'd1);
    n_ovf = 0; cyc(50, "t3_done");
    chk("t3_done_ovf", 32'(n_ovf), 32'd0);
    chk("t3_done_val", 32'({val, busy}), 32'h0);
    c_rst = 1; cyc(1, "t3_restart"); c_rst = 0;
    cyc(3, "t3_recount");
    chk("t3_recount_val", 32'(val), 32'd3);
    // external tick source 0
    c_os = 0; c_on = 0; cyc(1, "t4_stop");
    c_rst = 1; cyc(1, "t4_rst"); c_rst = 0;
    c_src = 1; c_on = 1; cyc(1, "t4_start");
    ext[0] = 1; ext[1] = 1'($urandom);
    cyc(2, "t4_sync");
    chk("t4_before_third", 32'(val), 32'd0);
    cyc(1, "t4_third");
    chk("t4_first_inc", 32'(val), 32'd1);
    ext[0] = 0; cyc(3, "t4_low");
    for (int p = 0; p < 9; p++) begin
      ext[0] = 1; ext[1] = 1'($urandom); cyc(3, "t4_high");
      ext[0] = 0; ext[1] = 1'($urandom); cyc(3, "t4_low");
    end
    cyc(3, "t4_tail");
    chk("t4_count10", 32'(val), 32'd10);
    // simultaneous strobes and held ld
    c_src = 0; cyc(3, "t5_run");
    mch = {8'h43, 8'h00}; ld_val = 8'h42;
    c_rst = 1; c_ld = 1; cyc(1, "t5_both");
    chk("t5_both_val", 32'({val, mf, ovf}), 32'h0);
    c_rst = 0; c_ld = 0; cyc(2, "t5_run2");
    c_ld = 1; cyc(5, "t5_ld_held"); c_ld = 0;
    chk("t5_ld_once", 32'(val), 32'h46);
    // asynchronous reset mid-count
    cyc(10, "t6_run");
    #2 rst_n = 1'b0;
    #1 chk("t6_async_zero", 32'({val, mf, ovf, tout, busy}), 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_idle_after", 32'({val, busy}), 32'h0);
    cyc(3, "t6_resume");
`ifdef TMR_GP_AUTO_RELOAD_EN
    c_on = 0; ld_val = 8'hF0; cyc(1, "t7_stop");
    c_ld = 1; cyc(1, "t7_ld"); c_ld = 0;
    c_on = 1; cyc(1, "t7_start");
    n_ovf = 0; cyc(16, "t7_period1");
    chk("t7_reload_val", 32'(val), 32'hF0);
    chk("t7_ovf_pulse", 32'(ovf), 32'd1);
    chk("t7_ovf_count1", 32'(n_ovf), 32'd1);
    n_ovf = 0; cyc(16, "t7_period2");
    chk("t7_ovf_count2", 32'(n_ovf), 32'd1);
`endif
    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      c_on = ($urandom_range(0, 19) != 0);
      c_rst = ($urandom_range(0, 29) == 0);
      c_ld = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 49) == 0) begin
        c_os = 1'($urandom); c_src = 2'($urandom); c_psc = 8'($urandom_range(0, 3));
      end
      c_oen = 1'($urandom); c_oinv = 1'($urandom);
      c_hi = 8'($urandom); c_mid = 6'($urandom); c_lo = 2'($urandom);
      if ($urandom_range(0, 9) == 0) mch = (NCH*W)'($urandom);
      ld_val = W'($urandom);
      if ($urandom_range(0, 2) == 0) ext = 2'($urandom);
      cyc(1, "rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
